// File: rtl/fetch_stage_bp.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_bp
//  Purpose  : Instruction-fetch stage. Owns the PC, addresses the instruction
//             ROM and registers the fetched word into IF/ID. Next-PC comes
//             from a 2-bit branch history table for conditional branches and
//             static-taken prediction for jumps. Handles stall, flush/redirect
//             and halt, and trains the BHT from EX-stage resolution.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_stage_bp #(
    parameter int          PC_W        = 8,
    parameter int          INSTR_W     = 16,
    parameter int          BHT_ENTRIES = 16,
    parameter logic [3:0]  BR_OPCODE   = 4'hC,
    parameter logic [3:0]  JMP_OPCODE  = 4'hD,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               update,
    input  logic [PC_W-1:0]    update_pc,
    input  logic               update_taken,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [PC_W-1:0]    PC_out_IF,
    output logic [INSTR_W-1:0] instruction_IF,
    output logic               predict_taken,
    output logic               valid_IF,
    output logic               halt
);

    localparam int           c_IDX_W   = $clog2(BHT_ENTRIES);
    localparam logic [1:0]   c_BHT_INIT = 2'b01;
    localparam logic [PC_W-1:0] c_PC_ONE = PC_W'(1);

    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    r_pc_if;
    logic [INSTR_W-1:0] r_instr_if;
    logic               r_pred_if;
    logic               r_valid_if;
    logic               r_halt;
    logic [1:0]         r_bht [BHT_ENTRIES];

    logic [3:0]         w_opcode;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic [c_IDX_W-1:0] w_upd_idx;
    logic [PC_W-1:0]    w_br_off;
    logic [PC_W-1:0]    w_next_pc;
    logic               w_pred;
    logic               w_is_halt;
    logic               w_unused_upd;

    assign w_opcode  = imem_data[INSTR_W-1 -: 4];
    assign w_rd_idx  = r_pc[c_IDX_W-1:0];
    assign w_upd_idx = update_pc[c_IDX_W-1:0];
    // Branch displacement is a signed 8-bit field, sign-extended to PC width.
    assign w_br_off  = PC_W'($signed(imem_data[7:0]));
    // Only the index bits of update_pc address the (untagged) BHT.
    assign w_unused_upd = ^update_pc;

    // Next-PC selection and prediction for the word currently on imem_data.
    // The BHT is read before any same-cycle update lands, so prediction sees
    // the pre-update counter.
    always_comb begin
        w_next_pc = r_pc + c_PC_ONE;
        w_pred    = 1'b0;
        w_is_halt = 1'b0;
        if (w_opcode == JMP_OPCODE) begin
            w_next_pc = PC_W'(imem_data[7:0]);
            w_pred    = 1'b1;
        end else if (w_opcode == BR_OPCODE && r_bht[w_rd_idx][1]) begin
            w_next_pc = r_pc + c_PC_ONE + w_br_off;
            w_pred    = 1'b1;
        end else if (w_opcode == HALT_OPCODE) begin
            w_next_pc = r_pc;
            w_is_halt = 1'b1;
        end
    end

    // PC, IF/ID register and halt flag: reset > flush > halt > stall > fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= '0;
            r_pc_if    <= '0;
            r_instr_if <= '0;
            r_pred_if  <= 1'b0;
            r_valid_if <= 1'b0;
            r_halt     <= 1'b0;
        end else if (flush) begin
            r_pc       <= redirect_pc;
            r_instr_if <= '0;
            r_pred_if  <= 1'b0;
            r_valid_if <= 1'b0;
            r_halt     <= 1'b0;
        end else if (r_halt) begin
            r_instr_if <= '0;
            r_pred_if  <= 1'b0;
            r_valid_if <= 1'b0;
        end else if (!stall) begin
            r_pc       <= w_next_pc;
            r_pc_if    <= r_pc;
            r_instr_if <= imem_data;
            r_pred_if  <= w_pred;
            r_valid_if <= 1'b1;
            if (w_is_halt) begin
                r_halt <= 1'b1;
            end
        end
    end

    // BHT training from EX resolution; runs regardless of stall/flush/halt.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= c_BHT_INIT;
            end
        end else if (update) begin
            if (update_taken) begin
                if (r_bht[w_upd_idx] != 2'b11) begin
                    r_bht[w_upd_idx] <= r_bht[w_upd_idx] + 2'b01;
                end
            end else begin
                if (r_bht[w_upd_idx] != 2'b00) begin
                    r_bht[w_upd_idx] <= r_bht[w_upd_idx] - 2'b01;
                end
            end
        end
    end

    assign imem_addr      = r_pc;
    assign PC_out_IF      = r_pc_if;
    assign instruction_IF = r_instr_if;
    assign predict_taken  = r_pred_if;
    assign valid_IF       = r_valid_if;
    assign halt           = r_halt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage_bp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage_bp
//  Purpose  : Directed self-checking bench for fetch_stage_bp: sequential
//             fetch and wrap, BHT training, stall, flush+stall, halt, jump,
//             negative branch offset and mid-run reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage_bp;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [7:0]  redirect_pc;
    logic        update;
    logic [7:0]  update_pc;
    logic        update_taken;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [7:0]  PC_out_IF;
    logic [15:0] instruction_IF;
    logic        predict_taken;
    logic        valid_IF;
    logic        halt;

    logic [15:0] rom [256];
    int          n_checks = 0;
    int          n_errors = 0;

    assign imem_data = rom[imem_addr];

    fetch_stage_bp dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .update         (update),
        .update_pc      (update_pc),
        .update_taken   (update_taken),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .PC_out_IF      (PC_out_IF),
        .instruction_IF (instruction_IF),
        .predict_taken  (predict_taken),
        .valid_IF       (valid_IF),
        .halt           (halt)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        stall  = 1'b0;
        flush  = 1'b0;
        update = 1'b0;
        step();
        step();
    endtask

    task automatic redirect_to(input logic [7:0] pc);
        flush       = 1'b1;
        redirect_pc = pc;
        step();
        flush       = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'(i);
        reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = '0;
        update = 1'b0; update_pc = '0; update_taken = 1'b0;

        // ---- 1: reset state, sequential fetch, PC wrap
        do_reset();
        chk("rst_pc_if",  32'(PC_out_IF),      32'h00);
        chk("rst_instr",  32'(instruction_IF), 32'h0000);
        chk("rst_valid",  32'(valid_IF),       32'h0);
        chk("rst_pred",   32'(predict_taken),  32'h0);
        chk("rst_halt",   32'(halt),           32'h0);
        chk("rst_addr",   32'(imem_addr),      32'h00);
        reset = 1'b0;
        for (int k = 1; k <= 257; k++) begin
            step();
            if (k == 1) begin
                chk("seq1_pc_if", 32'(PC_out_IF),      32'h00);
                chk("seq1_valid", 32'(valid_IF),       32'h1);
                chk("seq1_addr",  32'(imem_addr),      32'h01);
            end else if (k == 3) begin
                chk("seq3_pc_if", 32'(PC_out_IF),      32'h02);
                chk("seq3_instr", 32'(instruction_IF), 32'h0002);
            end else if (k == 256) begin
                chk("wrap_pc_if", 32'(PC_out_IF),      32'hFF);
                chk("wrap_instr", 32'(instruction_IF), 32'h00FF);
                chk("wrap_addr",  32'(imem_addr),      32'h00);
            end else if (k == 257) begin
                chk("wrap2_pc_if", 32'(PC_out_IF),     32'h00);
                chk("wrap2_addr",  32'(imem_addr),     32'h01);
            end
        end

        // ---- 2: conditional branch, weakly-not-taken then trained taken
        rom[8'h10] = 16'hC005;
        rom[8'h60] = 16'hC0FC;
        rom[8'h50] = 16'hD080;
        rom[8'h05] = 16'hF000;
        do_reset();
        reset = 1'b0;
        redirect_to(8'h10);
        chk("br_bubble_valid", 32'(valid_IF),  32'h0);
        chk("br_bubble_addr",  32'(imem_addr), 32'h10);
        step();
        chk("br1_pc_if", 32'(PC_out_IF),      32'h10);
        chk("br1_instr", 32'(instruction_IF), 32'hC005);
        chk("br1_pred",  32'(predict_taken),  32'h0);
        chk("br1_addr",  32'(imem_addr),      32'h11);
        update = 1'b1; update_pc = 8'h10; update_taken = 1'b1;
        step();
        step();
        update = 1'b0;
        redirect_to(8'h10);
        step();
        chk("br2_pc_if", 32'(PC_out_IF),     32'h10);
        chk("br2_pred",  32'(predict_taken), 32'h1);
        chk("br2_addr",  32'(imem_addr),     32'h16);

        // ---- 3: stall three cycles with PC at 0x20
        redirect_to(8'h1F);
        step();
        chk("st0_addr", 32'(imem_addr), 32'h20);
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("st_addr",  32'(imem_addr),      32'h20);
            chk("st_pc_if", 32'(PC_out_IF),      32'h1F);
            chk("st_instr", 32'(instruction_IF), 32'h001F);
            chk("st_valid", 32'(valid_IF),       32'h1);
        end
        stall = 1'b0;
        step();
        chk("st_res_pc_if", 32'(PC_out_IF), 32'h20);
        chk("st_res_addr",  32'(imem_addr), 32'h21);

        // ---- 4: flush overrides stall
        stall = 1'b1; flush = 1'b1; redirect_pc = 8'h40;
        step();
        stall = 1'b0; flush = 1'b0;
        chk("fs_valid", 32'(valid_IF),       32'h0);
        chk("fs_instr", 32'(instruction_IF), 32'h0000);
        chk("fs_addr",  32'(imem_addr),      32'h40);
        step();
        chk("fs_pc_if",  32'(PC_out_IF), 32'h40);
        chk("fs_valid2", 32'(valid_IF),  32'h1);

        // ---- 5: halt at 0x05, release by flush to 0x30
        do_reset();
        reset = 1'b0;
        repeat (6) step();
        chk("h_halt",  32'(halt),           32'h1);
        chk("h_pc_if", 32'(PC_out_IF),      32'h05);
        chk("h_instr", 32'(instruction_IF), 32'hF000);
        chk("h_valid", 32'(valid_IF),       32'h1);
        chk("h_pred",  32'(predict_taken),  32'h0);
        chk("h_addr",  32'(imem_addr),      32'h05);
        stall = 1'b1;
        step();
        step();
        stall = 1'b0;
        chk("h2_valid", 32'(valid_IF),       32'h0);
        chk("h2_instr", 32'(instruction_IF), 32'h0000);
        chk("h2_halt",  32'(halt),           32'h1);
        chk("h2_addr",  32'(imem_addr),      32'h05);
        redirect_to(8'h30);
        chk("h3_halt", 32'(halt),      32'h0);
        chk("h3_addr", 32'(imem_addr), 32'h30);
        step();
        chk("h4_pc_if", 32'(PC_out_IF), 32'h30);
        chk("h4_valid", 32'(valid_IF),  32'h1);

        // ---- 6: saturation at 0, training under stall, thresholds, jump
        do_reset();
        reset = 1'b0;
        update = 1'b1; update_pc = 8'h10; update_taken = 1'b0;
        repeat (4) step();
        update_taken = 1'b1; stall = 1'b1;
        step();
        update = 1'b0; stall = 1'b0;
        redirect_to(8'h10);
        step();
        chk("sat1_pred", 32'(predict_taken), 32'h0);
        chk("sat1_addr", 32'(imem_addr),     32'h11);
        update = 1'b1; update_pc = 8'h20; update_taken = 1'b1;
        step();
        update = 1'b0;
        redirect_to(8'h10);
        step();
        chk("sat2_pred", 32'(predict_taken), 32'h1);
        chk("sat2_addr", 32'(imem_addr),     32'h16);
        redirect_to(8'h60);
        step();
        chk("neg_pc_if", 32'(PC_out_IF),     32'h60);
        chk("neg_pred",  32'(predict_taken), 32'h1);
        chk("neg_addr",  32'(imem_addr),     32'h5D);
        redirect_to(8'h50);
        step();
        chk("jmp_pred", 32'(predict_taken), 32'h1);
        chk("jmp_addr", 32'(imem_addr),     32'h80);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mr_valid", 32'(valid_IF),  32'h0);
        chk("mr_addr",  32'(imem_addr), 32'h00);
        redirect_to(8'h10);
        step();
        chk("mr_pred", 32'(predict_taken), 32'h0);
        chk("mr_addr2", 32'(imem_addr),    32'h11);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
